// File: rtl/cmd_issue_queue_if.sv
// rtl/cmd_issue_queue_if.sv - host command/response and ALU issue signals of cmd_issue_queue
interface cmd_issue_queue_if #(
  parameter int DEPTH  = 4,
  parameter int OP_W   = 4,
  parameter int DATA_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic [OP_W-1:0]   iss_op;
  logic [DATA_W-1:0] iss_data;
  logic [DATA_W-1:0] alu_result;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [OP_W-1:0]   rsp_op;
  logic [DATA_W-1:0] rsp_data;
  logic [CNT_W-1:0]  fifo_count;
  logic              busy;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, alu_result, rsp_ready,
    output cmd_ready, iss_op, iss_data, rsp_valid, rsp_op, rsp_data, fifo_count, busy
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, alu_result, rsp_ready,
    input  cmd_ready, iss_op, iss_data, rsp_valid, rsp_op, rsp_data, fifo_count, busy
  );
endinterface

// File: rtl/cmd_issue_queue.sv
// rtl/cmd_issue_queue.sv - command FIFO that issues one command at a time to the ALU and returns tagged results
module cmd_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int OP_W   = 4,
  parameter int DATA_W = 32
) (
  input logic            clk,
  input logic            rst,
  cmd_issue_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, EXEC, RESP} state_t;

  state_t state, state_nxt;

  logic [OP_W-1:0]   op_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  logic push, pop, capture, rsp_done, empty;

  assign empty         = (count == '0);
  assign bus.cmd_ready = (count < FULL_COUNT);
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign bus.fifo_count = count;
  assign bus.busy      = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr]   <= bus.cmd_op;
      data_mem[wr_ptr] <= bus.cmd_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by plain overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!empty) state_nxt = ISSUE;
      ISSUE: state_nxt = EXEC;
      EXEC:  state_nxt = RESP;
      RESP:  if (bus.rsp_ready) state_nxt = empty ? IDLE : ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop      = 1'b0;
    capture  = 1'b0;
    rsp_done = 1'b0;
    case (state)
      IDLE:  pop = !empty;
      EXEC:  capture = 1'b1;
      RESP: begin
        rsp_done = bus.rsp_ready;
        pop      = bus.rsp_ready && !empty;
      end
      default: ;
    endcase
  end

  // The ALU samples iss_* every cycle, so they only move on a pop
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.iss_op    <= '0;
      bus.iss_data  <= '0;
      bus.rsp_op    <= '0;
      bus.rsp_data  <= '0;
      bus.rsp_valid <= 1'b0;
    end else begin
      if (pop) begin
        bus.iss_op   <= op_mem[rd_ptr];
        bus.iss_data <= data_mem[rd_ptr];
      end
      if (capture) begin
        bus.rsp_op    <= bus.iss_op;
        bus.rsp_data  <= bus.alu_result;
        bus.rsp_valid <= 1'b1;
      end else if (rsp_done) begin
        bus.rsp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cmd_issue_queue.sv
// tb/tb_cmd_issue_queue.sv - scoreboard bench for cmd_issue_queue with a registered ALU model
module tb_cmd_issue_queue;
  localparam int DEPTH = 4;
  localparam int OP_W = 4;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  cmd_issue_queue_if #(.DEPTH(DEPTH), .OP_W(OP_W), .DATA_W(DATA_W)) bus ();

  cmd_issue_queue #(.DEPTH(DEPTH), .OP_W(OP_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU model: regs are zero after reset, so add returns data and mul returns 0
  always @(posedge clk) begin
    if (rst) bus.alu_result <= '0;
    else     bus.alu_result <= (bus.iss_op == 0) ? bus.iss_data : '0;
  end

  logic [OP_W-1:0]   exp_op_q   [$];
  logic [DATA_W-1:0] exp_data_q [$];
  int                hs_q       [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Starts and ends at a negedge; holds cmd_valid until accepted
  task automatic send(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] data,
                      input logic [DATA_W-1:0] exp);
    int waited = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    while (!bus.cmd_ready && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.cmd_ready) begin
      check("send_timeout", 64'(waited), 64'd0);
    end else begin
      exp_op_q.push_back(op);
      exp_data_q.push_back(exp);
      @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    bus.cmd_valid = 1'b0;
    while ((exp_op_q.size() != 0 || bus.busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", 64'(exp_op_q.size()), 64'd0);
    check("drain_busy", 64'(bus.busy), 64'd0);
  endtask

  logic              hold_pending = 1'b0;
  logic [OP_W-1:0]   held_op;
  logic [DATA_W-1:0] held_data;

  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("rsp_hold_valid", 64'(bus.rsp_valid), 64'd1);
        check("rsp_hold_op", 64'(bus.rsp_op), 64'(held_op));
        check("rsp_hold_data", 64'(bus.rsp_data), 64'(held_data));
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        hold_pending = 1'b0;
        hs_q.push_back(cyc);
        if (exp_op_q.size() == 0) begin
          check("rsp_unexpected", 64'(bus.rsp_data), 64'hDEAD);
        end else begin
          check("rsp_op", 64'(bus.rsp_op), 64'(exp_op_q.pop_front()));
          check("rsp_data", 64'(bus.rsp_data), 64'(exp_data_q.pop_front()));
        end
      end else if (bus.rsp_valid) begin
        hold_pending = 1'b1;
        held_op      = bus.rsp_op;
        held_data    = bus.rsp_data;
      end else begin
        hold_pending = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int seen;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_count", 64'(bus.fifo_count), 64'd0);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_iss_op", 64'(bus.iss_op), 64'd0);
    check("rst_iss_data", 64'(bus.iss_data), 64'd0);

    // 1) single add, response three edges after accept
    bus.rsp_ready = 1'b1;
    send(4'd0, 32'd5, 32'd5);
    bus.cmd_valid = 1'b0;
    check("t1_count_p1", 64'(bus.fifo_count), 64'd1);
    @(negedge clk);
    check("t1_valid_p1", 64'(bus.rsp_valid), 64'd0);
    check("t1_count_pop", 64'(bus.fifo_count), 64'd0);
    @(negedge clk);
    check("t1_valid_p2", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    check("t1_valid_p3", 64'(bus.rsp_valid), 64'd1);
    drain();

    // 2) mul against zero register and unknown op
    send(4'd1, 32'd7, 32'd0);
    send(4'd2, 32'd9, 32'd0);
    drain();

    // 3) fill with rsp_ready low, then release
    bus.rsp_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(4'd0, 32'(i), 32'(i));
    check("t3_count_full", 64'(bus.fifo_count), 64'd4);
    check("t3_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    check("t3_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("t3_rsp_data", 64'(bus.rsp_data), 64'd1);
    fork
      send(4'd0, 32'd6, 32'd6);
      begin
        repeat (3) @(negedge clk);
        check("t3_stall", 64'(bus.cmd_ready), 64'd0);
        bus.rsp_ready = 1'b1;
      end
    join
    drain();

    // 4) three-entry burst at full throughput
    hs_q.delete();
    for (int i = 0; i < 3; i++) send(4'd0, 32'(32'h100 + i), 32'(32'h100 + i));
    drain();
    check("t4_rsp_count", 64'(hs_q.size()), 64'd3);
    if (hs_q.size() == 3) begin
      check("t4_gap01", 64'(hs_q[1] - hs_q[0]), 64'd3);
      check("t4_gap12", 64'(hs_q[2] - hs_q[1]), 64'd3);
    end

    // 5) push and pop on the same edge at count 2
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(4'd0, 32'(32'h21 + i), 32'(32'h21 + i));
    bus.cmd_valid = 1'b0;
    seen = 0;
    while (!bus.rsp_valid && seen < 20) begin
      @(negedge clk);
      seen++;
    end
    check("t5_count_before", 64'(bus.fifo_count), 64'd2);
    bus.rsp_ready = 1'b1;
    send(4'd0, 32'h24, 32'h24);
    check("t5_count_same", 64'(bus.fifo_count), 64'd2);
    for (int i = 5; i <= 7; i++) send(4'd0, 32'(32'h20 + i), 32'(32'h20 + i));
    drain();

    // 6) reset while EXEC with two commands queued
    send(4'd2, 32'hAB, 32'd0);
    send(4'd0, 32'h12, 32'h12);
    send(4'd0, 32'h13, 32'h13);
    bus.cmd_valid = 1'b0;
    check("t6_count_pre", 64'(bus.fifo_count), 64'd2);
    check("t6_iss_op_pre", 64'(bus.iss_op), 64'd2);
    check("t6_valid_pre", 64'(bus.rsp_valid), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("t6_count", 64'(bus.fifo_count), 64'd0);
    check("t6_iss_op", 64'(bus.iss_op), 64'd0);
    check("t6_iss_data", 64'(bus.iss_data), 64'd0);
    exp_op_q.delete();
    exp_data_q.delete();
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    check("t6_no_stale", 64'(seen), 64'd0);
    check("t6_busy", 64'(bus.busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
